// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_slice.sv
// One-bit full adder/subtractor: b is inverted when m=1 so the same
// slice produces a+~b+cin; the caller supplies cin=1 on bit 0 for subtract.
module add_sub_slice (
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic m,
  output logic s,
  output logic cout
);

  logic b_x;

  assign b_x  = b ^ m;
  assign s    = a ^ b_x ^ cin;
  assign cout = (a & b_x) | (cin & (a ^ b_x));

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Bit-serial add/subtract sequencer: feeds one slice LSB-first, one bit per
// clock, and captures carry-out and signed overflow on the last bit.
//
// state | meaning
// IDLE  | waiting for start; last result and flags remain visible
// RUN   | one operand bit processed per clock, LSB first
// DONE  | single cycle, done pulse high, then back to IDLE
module serial_add_sub_ctrl
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sum_bit;
  logic             cout_bit;

  add_sub_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .m    (mode_q),
    .s    (sum_bit),
    .cout (cout_bit)
  );

  // Next-state, datapath shifting and flag capture.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          // Subtract needs the +1 of the two's complement on bit 0.
          carry_d = (mode == MODE_SUB);
          cnt_d   = '0;
        end
      end
      RUN: begin
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = cout_bit;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          cout_d  = cout_bit;
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ cout_bit;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = res_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// Self-checking bench for serial_add_sub_ctrl (WIDTH=8).
module tb_serial_add_sub_ctrl;
  import serial_add_sub_pkg::*;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         mode  = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_sub_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, returns {overflow, carry, result}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic m);
    int ux, uy, sx, sy, us, ss;
    logic ov, cy;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (m == MODE_SUB) begin
      us = ux + ((1 << W) - 1 - uy) + 1;
      ss = sx - sy;
    end else begin
      us = ux + uy;
      ss = sx + sy;
    end
    ov = (ss > ((1 << (W-1)) - 1)) || (ss < -(1 << (W-1)));
    cy = (us >= (1 << W));
    return {ov, cy, us[W-1:0]};
  endfunction

  // Wait for IDLE, present operands for one accepting edge, then scramble inputs.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < W + 4) begin
      @(negedge clk);
      guard++;
    end
    if (busy || done) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_op_idle_timeout busy=%0b done=%0b", busy, done);
    end
    a = x; b = y; mode = m; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    mode = 1'($urandom);
  endtask

  // Called in the cycle after the accepting edge; returns in the DONE cycle.
  task automatic finish_op(input logic [W-1:0] er, input logic ec, input logic eo,
                           input string name);
    int busy_cycles, lat;
    bit got;
    busy_cycles = busy ? 1 : 0;
    got = 0;
    lat = 0;
    for (int e = 1; e <= W + 4; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        got = 1;
        lat = e;
        break;
      end
      if (busy) busy_cycles++;
    end
    n_checks++;
    if (!got || lat != W) begin
      n_fail++;
      $display("FAIL %s latency got=%0d seen=%0b expected=%0d", name, lat, got, W);
    end
    n_checks++;
    if (busy_cycles != W) begin
      n_fail++;
      $display("FAIL %s busy_cycles got=%0d expected=%0d", name, busy_cycles, W);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_in_done got=%0b expected=0", name, busy);
    end
    n_checks++;
    if (result !== er) begin
      n_fail++;
      $display("FAIL %s result got=%h expected=%h", name, result, er);
    end
    n_checks++;
    if (carry_out !== ec) begin
      n_fail++;
      $display("FAIL %s carry_out got=%0b expected=%0b", name, carry_out, ec);
    end
    n_checks++;
    if (overflow !== eo) begin
      n_fail++;
      $display("FAIL %s overflow got=%0b expected=%0b", name, overflow, eo);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({busy, done, result, carry_out, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b expected=0", {busy, done, result, carry_out, overflow});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    start_op(8'h05, 8'h03, MODE_ADD); finish_op(8'h08, 1'b0, 1'b0, "add_05_03");
    start_op(8'h7F, 8'h01, MODE_ADD); finish_op(8'h80, 1'b0, 1'b1, "add_7f_01");
    start_op(8'hFF, 8'h01, MODE_ADD); finish_op(8'h00, 1'b1, 1'b0, "add_ff_01");
    start_op(8'h05, 8'h03, MODE_SUB); finish_op(8'h02, 1'b1, 1'b0, "sub_05_03");
    start_op(8'h03, 8'h05, MODE_SUB); finish_op(8'hFE, 1'b0, 1'b0, "sub_03_05");
    start_op(8'h80, 8'h01, MODE_SUB); finish_op(8'h7F, 1'b1, 1'b1, "sub_80_01");
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic m;
    logic [W+1:0] exp_v;
    for (int i = 0; i < 24; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      m = 1'($urandom);
      exp_v = ref_op(x, y, m);
      start_op(x, y, m);
      finish_op(exp_v[W-1:0], exp_v[W], exp_v[W+1], "random");
    end
  endtask

  // done is a single pulse; results persist through IDLE.
  task automatic test_hold();
    start_op(8'h80, 8'h01, MODE_SUB);
    finish_op(8'h7F, 1'b1, 1'b1, "hold_op");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({done, busy, result, carry_out, overflow} !== {1'b0, 1'b0, 8'h7F, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL hold_idle cycle=%0d got done=%0b busy=%0b res=%h c=%0b o=%0b", i, done,
                 busy, result, carry_out, overflow);
      end
    end
  endtask

  task automatic test_ignore_start();
    int dcnt;
    bit prev_done;
    dcnt = 0;
    prev_done = 0;
    start_op(8'h12, 8'h34, MODE_ADD);
    for (int e = 1; e <= W + 6; e++) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
      if (e == 3) begin
        start = 1'b1; a = 8'hAA; b = 8'h55; mode = MODE_SUB;
      end else if (e == 4) begin
        start = 1'b0;
      end
      if (done) begin
        start = 1'b1; a = 8'h01; b = 8'h02; mode = MODE_SUB;
      end else if (prev_done) begin
        start = 1'b0;
      end
      prev_done = done;
    end
    start = 1'b0;
    n_checks++;
    if (dcnt != 1) begin
      n_fail++;
      $display("FAIL ignore_start done_pulses got=%0d expected=1", dcnt);
    end
    n_checks++;
    if ({busy, result, carry_out, overflow} !== {1'b0, 8'h46, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL ignore_start final got busy=%0b res=%h c=%0b o=%0b expected 0 46 0 0",
               busy, result, carry_out, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int dcnt;
    start_op(8'h5A, 8'h21, MODE_ADD);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, result, carry_out, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got=%b expected=0", {busy, done, result, carry_out, overflow});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    repeat (W + 2) begin
      @(posedge clk);
      #1;
      if (done || busy) dcnt++;
    end
    n_checks++;
    if (dcnt != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_activity got=%0d expected=0", dcnt);
    end
    start_op(8'h5A, 8'h21, MODE_ADD);
    finish_op(8'h7B, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    start_op(8'h10, 8'h20, MODE_ADD);
    finish_op(8'h30, 1'b0, 1'b0, "b2b_first");
    start = 1'b1; a = 8'h20; b = 8'h30; mode = MODE_SUB;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_edge busy got=%0b expected=0", busy);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept busy got=%0b expected=1", busy);
    end
    finish_op(8'hF0, 1'b0, 1'b0, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
